// File: rtl/div_share_arbiter_pkg.sv
// Shared types and helpers for the divider-sharing arbiter.
package div_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } div_arb_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CLZ_W      = $clog2(DEF_DATA_WIDTH);

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_share_arbiter_picker.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module rr_priority_picker
    import div_share_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int            pos;
    logic [IW-1:0] idx;

    // Walk the N positions starting at ptr and keep the first requester seen.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        pos          = 0;
        idx          = '0;
        for (int off = 0; off < N; off++) begin
            pos = (int'(ptr) + off) % N;
            idx = IW'(pos);
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one multi-cycle unsigned divider between NUM_REQ requesters.
// Round-robin grant, ownership held until the divider's done, result
// routed only to the owner unless the owner flushed meanwhile.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CLZ_W      = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*CLZ_W-1:0]      req_dividend_clz,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
    input  logic [NUM_REQ*CLZ_W-1:0]      req_divisor_clz,
    input  logic [NUM_REQ-1:0]            req_div_by_zero,
    input  logic [NUM_REQ-1:0]            req_flush,
    output logic [NUM_REQ-1:0]            req_accept,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic [DATA_WIDTH-1:0]         rsp_quotient,
    output logic [DATA_WIDTH-1:0]         rsp_remainder,
    output logic                          div_start,
    output logic [DATA_WIDTH-1:0]         div_dividend,
    output logic [CLZ_W-1:0]              div_dividend_clz,
    output logic [DATA_WIDTH-1:0]         div_divisor,
    output logic [CLZ_W-1:0]              div_divisor_clz,
    output logic                          div_divisor_is_zero,
    input  logic [DATA_WIDTH-1:0]         div_quotient,
    input  logic [DATA_WIDTH-1:0]         div_remainder,
    input  logic                          div_done
);

    localparam int IW = idx_width(NUM_REQ);

    div_arb_state_t       state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        owner;
    logic                 discard;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IW-1:0]        grant_idx;
    logic [IW-1:0]        next_ptr;
    logic                 any;
    logic                 owner_flush;

    logic [DATA_WIDTH-1:0] dvd     [NUM_REQ];
    logic [DATA_WIDTH-1:0] dvs     [NUM_REQ];
    logic [CLZ_W-1:0]      dvd_clz [NUM_REQ];
    logic [CLZ_W-1:0]      dvs_clz [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dvd[i]     = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
        assign dvs[i]     = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
        assign dvd_clz[i] = req_dividend_clz[i*CLZ_W +: CLZ_W];
        assign dvs_clz[i] = req_divisor_clz[i*CLZ_W +: CLZ_W];
    end

    // A requester flushing this cycle must not be granted this cycle.
    assign eligible    = req_valid & ~req_flush;
    assign owner_flush = req_flush[owner];
    assign next_ptr    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req          (eligible),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    // Accept is combinational so the requester sees it in the grant cycle;
    // held low during reset so every output reads zero while rst is high.
    assign req_accept = (state == IDLE && !rst) ? grant_onehot : '0;

    // Arbitration FSM with registered operand, start and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            owner               <= '0;
            discard             <= 1'b0;
            div_start           <= 1'b0;
            div_dividend        <= '0;
            div_dividend_clz    <= '0;
            div_divisor         <= '0;
            div_divisor_clz     <= '0;
            div_divisor_is_zero <= 1'b0;
            rsp_done            <= '0;
            rsp_quotient        <= '0;
            rsp_remainder       <= '0;
        end else begin
            div_start <= 1'b0;
            rsp_done  <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        div_dividend        <= dvd[grant_idx];
                        div_dividend_clz    <= dvd_clz[grant_idx];
                        div_divisor         <= dvs[grant_idx];
                        div_divisor_clz     <= dvs_clz[grant_idx];
                        div_divisor_is_zero <= req_div_by_zero[grant_idx];
                        owner               <= grant_idx;
                        discard             <= 1'b0;
                        rr_ptr              <= next_ptr;
                        div_start           <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (owner_flush) discard <= 1'b1;
                    state <= BUSY;
                end
                BUSY: begin
                    if (owner_flush) discard <= 1'b1;
                    if (div_done) begin
                        // A flush landing on the done cycle still kills the response.
                        if (!discard && !owner_flush) begin
                            rsp_done[owner] <= 1'b1;
                            rsp_quotient    <= div_quotient;
                            rsp_remainder   <= div_remainder;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A done while issuing means the divider finished something it was never
    // started on. A done in IDLE is tolerated: it follows a mid-op reset.
    a_no_done_in_issue: assert property (@(posedge clk) disable iff (rst)
        !(div_done && state == ISSUE));

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency divider model.
module tb_div_share_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int K  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_dividend;
    logic [NR*CW-1:0]  req_dividend_clz;
    logic [NR*DW-1:0]  req_divisor;
    logic [NR*CW-1:0]  req_divisor_clz;
    logic [NR-1:0]     req_div_by_zero;
    logic [NR-1:0]     req_flush;
    logic [NR-1:0]     req_accept;
    logic [NR-1:0]     rsp_done;
    logic [DW-1:0]     rsp_quotient;
    logic [DW-1:0]     rsp_remainder;
    logic              div_start;
    logic [DW-1:0]     div_dividend;
    logic [CW-1:0]     div_dividend_clz;
    logic [DW-1:0]     div_divisor;
    logic [CW-1:0]     div_divisor_clz;
    logic              div_divisor_is_zero;
    logic [DW-1:0]     div_quotient;
    logic [DW-1:0]     div_remainder;
    logic              div_done;

    div_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CLZ_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_dividend        (req_dividend),
        .req_dividend_clz    (req_dividend_clz),
        .req_divisor         (req_divisor),
        .req_divisor_clz     (req_divisor_clz),
        .req_div_by_zero     (req_div_by_zero),
        .req_flush           (req_flush),
        .req_accept          (req_accept),
        .rsp_done            (rsp_done),
        .rsp_quotient        (rsp_quotient),
        .rsp_remainder       (rsp_remainder),
        .div_start           (div_start),
        .div_dividend        (div_dividend),
        .div_dividend_clz    (div_dividend_clz),
        .div_divisor         (div_divisor),
        .div_divisor_clz     (div_divisor_clz),
        .div_divisor_is_zero (div_divisor_is_zero),
        .div_quotient        (div_quotient),
        .div_remainder       (div_remainder),
        .div_done            (div_done)
    );

    always #5 clk = ~clk;

    // Divider model: done K cycles after the accept, i.e. K-1 after start.
    // Not reset by rst, so an op cut short by reset still produces a stray done.
    int          dcnt  = 0;
    logic        mdone = 1'b0;
    logic [31:0] mq    = '0;
    logic [31:0] mr    = '0;
    always @(posedge clk) begin
        mdone <= 1'b0;
        if (div_start) begin
            dcnt <= K - 2;
            mq   <= div_divisor_is_zero ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            mr   <= div_divisor_is_zero ? div_dividend : div_dividend % div_divisor;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) mdone <= 1'b1;
        end
    end
    assign div_done      = mdone;
    assign div_quotient  = mq;
    assign div_remainder = mr;

    // Event log, sampled mid-cycle.
    int          cyc = 0;
    int          acc_c[$];
    logic [1:0]  acc_v[$];
    int          st_c[$];
    int          dn_c[$];
    int          rsp_c[$];
    logic [1:0]  rsp_v[$];
    logic [31:0] rsp_qv[$];
    logic [31:0] rsp_rv[$];
    int          multi_err = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (req_accept != 0) begin acc_c.push_back(cyc); acc_v.push_back(req_accept); end
        if (div_start) st_c.push_back(cyc);
        if (div_done) dn_c.push_back(cyc);
        if (rsp_done != 0) begin
            rsp_c.push_back(cyc); rsp_v.push_back(rsp_done);
            rsp_qv.push_back(rsp_quotient); rsp_rv.push_back(rsp_remainder);
        end
        if (!$onehot0(req_accept) || !$onehot0(rsp_done)) multi_err <= multi_err + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic clr();
        acc_c.delete(); acc_v.delete(); st_c.delete(); dn_c.delete();
        rsp_c.delete(); rsp_v.delete(); rsp_qv.delete(); rsp_rv.delete();
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [4:0] ac,
                          input logic [31:0] b, input logic [4:0] bc, input logic z);
        req_dividend[i*DW +: DW]     = a;
        req_dividend_clz[i*CW +: CW] = ac;
        req_divisor[i*DW +: DW]      = b;
        req_divisor_clz[i*CW +: CW]  = bc;
        req_div_by_zero[i]           = z;
    endtask

    task automatic rst_pulse();
        step(); rst = 1'b1;
        step(); rst = 1'b0; clr();
    endtask

    task automatic wait_rsp(input int n, input int max, input string tag);
        for (int i = 0; i < max && rsp_c.size() < n; i++) settle();
        chk(tag, rsp_c.size(), n);
    endtask

    task automatic wait_acc(input int n, input int max, input string tag);
        for (int i = 0; i < max && acc_c.size() < n; i++) step();
        chk(tag, acc_c.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_flush = '0;
        req_dividend = '0; req_dividend_clz = '0; req_divisor = '0;
        req_divisor_clz = '0; req_div_by_zero = '0;
        repeat (2) step();
        settle();
        chk("rst_accept", req_accept, 0);
        chk("rst_rsp_done", rsp_done, 0);
        chk("rst_start", div_start, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_quotient", rsp_quotient, 0);

        // Single request 100/7.
        step(); rst = 1'b0; clr();
        set_op(0, 100, 25, 7, 29, 1'b0);
        req_valid = 2'b01;
        settle(); chk("t1_accept", req_accept, 2'b01);
        step(); req_valid = 2'b00;
        settle();
        chk("t1_start", div_start, 1);
        chk("t1_dividend", div_dividend, 100);
        chk("t1_divisor", div_divisor, 7);
        chk("t1_dvd_clz", div_dividend_clz, 25);
        chk("t1_dvs_clz", div_divisor_clz, 29);
        chk("t1_dbz", div_divisor_is_zero, 0);
        wait_rsp(1, 20, "t1_rsp_cnt");
        chk("t1_lat_start", st_c[0] - acc_c[0], 1);
        chk("t1_lat_done", dn_c[0] - acc_c[0], 5);
        chk("t1_lat_rsp", rsp_c[0] - acc_c[0], 6);
        chk("t1_rsp_vec", rsp_v[0], 2'b01);
        chk("t1_q", rsp_qv[0], 14);
        chk("t1_r", rsp_rv[0], 2);
        settle();
        chk("t1_pulse", rsp_done, 0);
        chk("t1_hold_q", rsp_quotient, 14);

        // Contention: both held, alternating grants and routed results.
        set_op(0, 100, 25, 7, 29, 1'b0);
        set_op(1, 50, 26, 5, 29, 1'b0);
        req_valid = 2'b11;
        rst_pulse();
        wait_acc(4, 60, "t2_acc_cnt");
        req_valid = 2'b00;
        wait_rsp(4, 40, "t2_rsp_cnt");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_acc%0d", i), acc_v[i], (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("t2_rsp%0d", i), rsp_v[i], (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("t2_q%0d", i), rsp_qv[i], (i % 2) ? 10 : 14);
            chk($sformatf("t2_r%0d", i), rsp_rv[i], (i % 2) ? 0 : 2);
        end
        chk("t2_b2b", acc_c[1], rsp_c[0]);
        chk("t2_onehot", multi_err, 0);

        // Flush of owner while BUSY; the other requester is served next.
        rst_pulse();
        req_valid = 2'b10;
        settle(); chk("t3_accept1", req_accept, 2'b10);
        step(); req_valid = 2'b01;
        step();
        step(); req_flush = 2'b10;
        step(); req_flush = 2'b00;
        wait_acc(2, 20, "t3_acc_cnt");
        req_valid = 2'b00;
        wait_rsp(1, 20, "t3_rsp_cnt");
        repeat (4) settle();
        chk("t3_rsp_only", rsp_c.size(), 1);
        chk("t3_rsp_vec", rsp_v[0], 2'b01);
        chk("t3_q", rsp_qv[0], 14);
        chk("t3_acc_vec", acc_v[1], 2'b01);
        chk("t3_acc_gap", acc_c[1] - acc_c[0], 6);
        chk("t3_starts", st_c.size(), 2);

        // Flush on the div_done cycle, then flush with valid in IDLE.
        rst_pulse();
        req_valid = 2'b01;
        settle(); chk("t4_accept", req_accept, 2'b01);
        step(); req_valid = 2'b00;
        repeat (4) step();
        req_flush = 2'b01;
        settle(); chk("t4_done_cyc", div_done, 1);
        step(); req_flush = 2'b00;
        settle(); chk("t4_no_rsp", rsp_done, 0);
        repeat (3) settle();
        chk("t4_rsp_cnt", rsp_c.size(), 0);
        step(); req_valid = 2'b10; req_flush = 2'b10;
        settle(); chk("t4_flush_idle", req_accept, 2'b00);
        step(); req_flush = 2'b00;
        settle(); chk("t4_after_flush", req_accept, 2'b10);
        step(); req_valid = 2'b00;
        wait_rsp(1, 20, "t4_rsp1_cnt");
        chk("t4_rsp1_vec", rsp_v[0], 2'b10);

        // Back-to-back with divide-by-zero passthrough.
        rst_pulse();
        set_op(0, 9, 28, 0, 31, 1'b1);
        req_valid = 2'b01;
        settle(); chk("t5_accept", req_accept, 2'b01);
        step();
        settle();
        chk("t5_dbz", div_divisor_is_zero, 1);
        chk("t5_divisor", div_divisor, 0);
        wait_acc(2, 30, "t5_acc_cnt");
        req_valid = 2'b00;
        wait_rsp(2, 30, "t5_rsp_cnt");
        chk("t5_b2b", acc_c[1], rsp_c[0]);
        chk("t5_q", rsp_qv[0], 32'hFFFF_FFFF);
        chk("t5_r", rsp_rv[0], 9);

        // Async reset mid-BUSY, then a stray done from the divider.
        set_op(0, 100, 25, 7, 29, 1'b0);
        step(); req_valid = 2'b01;
        settle(); chk("t6_accept", req_accept, 2'b01);
        step(); req_valid = 2'b00;
        step();
        step(); req_valid = 2'b01; rst = 1'b1;
        #1;
        chk("t6_rst_q", rsp_quotient, 0);
        chk("t6_rst_r", rsp_remainder, 0);
        chk("t6_rst_dvd", div_dividend, 0);
        chk("t6_rst_accept", req_accept, 0);
        chk("t6_rst_rsp", rsp_done, 0);
        step(); rst = 1'b0; req_valid = 2'b00; clr();
        repeat (6) settle();
        chk("t6_stray_seen", dn_c.size(), 1);
        chk("t6_no_rsp", rsp_c.size(), 0);
        chk("t6_no_start", st_c.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
